// File: rtl/ret_stack_ctrl_if.sv
// Push/pop handshake and status bundle between the control unit and the return-address stack.
interface ret_stack_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_addr;
  logic              clr_err;
  logic [DATA_W-1:0] top_addr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, push_addr, clr_err,
    input  top_addr, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, push_addr, clr_err,
    output top_addr, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/ret_stack_ctrl.sv
// Circular return-address LIFO with sticky overflow/underflow tracking.
// Define RET_STACK_WRAP_EN to let a push while full overwrite the oldest entry instead of being dropped.
module ret_stack_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input logic             clk,
  input logic             reset,
  ret_stack_ctrl_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, top_ptr, waddr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, full_q;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              we;
  logic              is_empty, is_full;

  assign top_ptr  = wr_ptr_q - PTR_W'(1);
  assign is_empty = (count_q == CNT_W'(0));
  assign is_full  = (count_q == CNT_W'(DEPTH));

  // Next-state decode of the {push, pop} strobe pair
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    ovf_d    = ovf_q & ~bus.clr_err;
    unf_d    = unf_q & ~bus.clr_err;
    case ({bus.push, bus.pop})
      2'b10: begin
        if (!is_full) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d  = count_q + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
`ifdef RET_STACK_WRAP_EN
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
`endif
        end
      end
      2'b01: begin
        if (!is_empty) begin
          wr_ptr_d = wr_ptr_q - PTR_W'(1);
          count_d  = count_q - CNT_W'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      2'b11: begin
        we = 1'b1;
        if (!is_empty) begin
          waddr = top_ptr;
        end else begin
          unf_d    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d  = CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == CNT_W'(0));
      full_q   <= (count_d == CNT_W'(DEPTH));
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is never cleared; reset only drops the write
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      mem[waddr] <= bus.push_addr;
    end
  end

  assign bus.top_addr  = is_empty ? '0 : mem[top_ptr];
  assign bus.count     = count_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_ret_stack_ctrl.sv
// Directed vector bench for ret_stack_ctrl (DEPTH=16); expectations follow RET_STACK_WRAP_EN when defined.
module tb_ret_stack_ctrl;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NVEC   = 20;

  typedef struct {
    logic        rst, push, pop, clr;
    logic [31:0] addr;
    logic [4:0]  cnt;
    logic [31:0] top;
    logic        emp, ful, ovf, unf;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ret_stack_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  ret_stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, p, q, c, input logic [31:0] a,
                              input logic [4:0] n, input logic [31:0] t,
                              input logic e, f, o, u);
    vec_t v;
    v.rst = r; v.push = p; v.pop = q; v.clr = c; v.addr = a;
    v.cnt = n; v.top = t; v.emp = e; v.ful = f; v.ovf = o; v.unf = u;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, p, q, c, input logic [31:0] a);
    reset         = r;
    bus.push      = p;
    bus.pop       = q;
    bus.clr_err   = c;
    bus.push_addr = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [4:0] n, input logic [31:0] t,
                             input logic e, f, o, u);
    check({name, ".count"},     32'(bus.count), 32'(n));
    check({name, ".top"},       bus.top_addr, t);
    check({name, ".empty"},     32'(bus.empty), 32'(e));
    check({name, ".full"},      32'(bus.full), 32'(f));
    check({name, ".overflow"},  32'(bus.overflow), 32'(o));
    check({name, ".underflow"}, 32'(bus.underflow), 32'(u));
  endtask

  logic [31:0] exp_top;

  initial begin
    //                rst push pop clr addr     cnt  top      emp ful ovf unf
    vecs[0]  = mk(1, 0, 0, 0, 32'h0,  0, 32'h0,  1, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 32'h7,  0, 32'h0,  1, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 32'h10, 1, 32'h10, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 32'h20, 2, 32'h20, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 32'h30, 3, 32'h30, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 1, 0, 32'h0,  2, 32'h20, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 0, 32'h0,  1, 32'h10, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 0, 1);
    vecs[9]  = mk(0, 0, 0, 1, 32'h0,  0, 32'h0,  1, 0, 0, 0);
    vecs[10] = mk(0, 1, 0, 0, 32'h33, 1, 32'h33, 0, 0, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 32'h44, 2, 32'h44, 0, 0, 0, 0);
    vecs[12] = mk(0, 1, 1, 0, 32'h55, 2, 32'h55, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 1, 0, 32'h0,  1, 32'h33, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 0, 0);
    vecs[15] = mk(0, 1, 1, 0, 32'h66, 1, 32'h66, 0, 0, 0, 1);
    vecs[16] = mk(0, 0, 1, 1, 32'h0,  0, 32'h0,  1, 0, 0, 0);
    vecs[17] = mk(0, 0, 1, 1, 32'h0,  0, 32'h0,  1, 0, 0, 1);
    vecs[18] = mk(0, 0, 0, 1, 32'h0,  0, 32'h0,  1, 0, 0, 0);
    vecs[19] = mk(1, 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 0, 0);

    drive(1, 0, 0, 0, 32'h0);
    step();

    // top_addr must already hold the popped entry before the retiring edge
    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].addr);
      if (vecs[i].pop && !vecs[i].rst && i > 0) begin
        #1;
        check($sformatf("v%0d.pop_top", i), bus.top_addr, vecs[i-1].top);
      end
      step();
      check_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].top,
                  vecs[i].emp, vecs[i].ful, vecs[i].ovf, vecs[i].unf);
    end

    // Fill to DEPTH, then push once more while full
    drive(1, 0, 0, 0, 32'h0);
    step();
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(0, 1, 0, 0, 32'h100 + 32'(i));
      step();
    end
    drive(0, 0, 0, 0, 32'h0);
    check_state("filled", 5'd16, 32'h10F, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 32'h200);
    step();
`ifdef RET_STACK_WRAP_EN
    check_state("ovf_push", 5'd16, 32'h200, 0, 1, 1, 0);
`else
    check_state("ovf_push", 5'd16, 32'h10F, 0, 1, 1, 0);
`endif
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(0, 0, 1, 0, 32'h0);
`ifdef RET_STACK_WRAP_EN
      exp_top = (i == 0) ? 32'h200 : 32'h10F - 32'(i - 1);
`else
      exp_top = 32'h10F - 32'(i);
`endif
      #1;
      check($sformatf("drain%0d.top", i), bus.top_addr, exp_top);
      step();
    end
    drive(0, 0, 0, 0, 32'h0);
    check_state("drained", 5'd0, 32'h0, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 32'h0);
    step();
    check_state("ovf_clr", 5'd0, 32'h0, 1, 0, 0, 0);

    // Pointer wrap: oscillate between count 15 and 16 so wr_ptr crosses 0
    drive(1, 0, 0, 0, 32'h0);
    step();
    for (int i = 0; i < 15; i++) begin
      drive(0, 1, 0, 0, 32'h1000 + 32'(i));
      step();
    end
    for (int k = 0; k < 40; k++) begin
      drive(0, 1, 0, 0, 32'h2000 + 32'(k));
      step();
      check($sformatf("wrap%0d.push_top", k), bus.top_addr, 32'h2000 + 32'(k));
      drive(0, 0, 1, 0, 32'h0);
      #1;
      check($sformatf("wrap%0d.pop_top", k), bus.top_addr, 32'h2000 + 32'(k));
      step();
      check($sformatf("wrap%0d.after", k), bus.top_addr, 32'h100E);
    end
    check("wrap.count", 32'(bus.count), 32'd15);
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 1, 0, 32'h0);
      #1;
      check($sformatf("unwind%0d.top", i), bus.top_addr, 32'h100E - 32'(i));
      step();
    end
    drive(0, 0, 0, 0, 32'h0);
    check_state("unwound", 5'd0, 32'h0, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ret_stack_ctrl.md
# ret_stack_ctrl

Return-address stack controller for the multicycle processor: it stores return addresses pushed by `jal` and supplies them to the PC-source mux for `jst`. It accepts the control unit's single-cycle `push`/`pop` strobes and owns a circular LIFO buffer with its pointer and occupancy count. It also tracks overflow/underflow so software bugs in call nesting are visible instead of silently corrupting the PC.

## Interface
- `DATA_W`, 32: return-address width; matches the PC width.
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `PTR_W`, log2(DEPTH): pointer width; derived, not overridden.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `push`  in  1  push `push_addr` this cycle; one operation per high cycle.
- `pop`  in  1  pop the top entry this cycle; one operation per high cycle.
- `push_addr`  in  DATA_W  return address to store, typically PC+1 from the datapath.
- `clr_err`  in  1  clears the sticky `overflow`/`underflow` flags.
- `top_addr`  out  DATA_W  current top of stack; combinational from storage; 0 when empty.
- `count`  out  PTR_W+1  occupancy, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky: a push occurred while full.
- `underflow`  out  1  sticky: a pop occurred while empty.

## Operation
- Storage is a DEPTH-entry register array.
- `wr_ptr` (PTR_W bits) indexes the next free slot.
- `top_addr = mem[wr_ptr-1]` (modulo DEPTH) when `count != 0`, else 0.
- Operation per rising edge, decoded from {push, pop}:
  - 00: idle; no state change.
  - 10, not full: `mem[wr_ptr] <= push_addr`; `wr_ptr`+1; `count`+1.
  - 10, full: behaviour set by the Configuration macro; `overflow <= 1`.
  - 01, not empty: `wr_ptr`−1; `count`−1. The entry is not cleared.
  - 01, empty: no change; `underflow <= 1`.
  - 11, not empty: replace the top, `mem[wr_ptr-1] <= push_addr`; `wr_ptr` and `count` unchanged; no flag set.
  - 11, empty: the pop is ignored, `underflow <= 1`, and the push is performed normally (`count` becomes 1).
- Pointer arithmetic is modulo DEPTH (natural PTR_W wrap). `count` saturates within 0..DEPTH and never wraps.
- `clr_err` clears both sticky flags. If a new error occurs in the same cycle as `clr_err`, the new error wins and the flag is set.
- Sticky flags do not block operation.

## Timing
- Reset (synchronous, priority over all inputs): `wr_ptr=0`, `count=0`, `empty=1`, `full=0`, `overflow=0`, `underflow=0`, `top_addr=0`. Array contents are undefined and not cleared.
- `top_addr` is valid throughout the cycle in which `pop` is high. This lets the PC register load the return address on the same edge that retires the entry (`jst` asserts `pop` together with PC-source select 11).
- A push is visible on `top_addr`, `count` and the flags in the cycle after the edge that performed it. The same holds for a pop.
- Latency: push or pop takes 1 cycle; flags are set on the same edge as the offending operation.
- Reset asserted mid-sequence, including in the same cycle as push or pop: the reset wins and the operation is dropped.
- `push` and `pop` are sampled as levels. The control unit drives each high for exactly one cycle per instruction; holding one high for N cycles performs N operations.

## Configuration
- `RET_STACK_WRAP_EN` defined:
  - A push while full overwrites the oldest entry, i.e. the slot at `wr_ptr`, which equals the bottom when full.
  - `wr_ptr`+1; `count` stays DEPTH; `overflow <= 1`.
  - The deepest return address is lost; the most recent DEPTH entries remain poppable.
- Not defined:
  - A push while full is discarded; `wr_ptr`, `count` and `mem` are unchanged; `overflow <= 1`.
  - The existing DEPTH entries remain intact.

## Test plan
- Reset, then push 0x10, 0x20, 0x30 -> `count=3`, `top_addr=0x30`; pop ×3 -> `top_addr` reads 0x30, 0x20, 0x10 during the respective pop cycles; `empty=1`, `top_addr=0`.
- Pop while empty -> `count` stays 0, `underflow=1`. Then `clr_err` for 1 cycle -> `underflow=0`.
- With DEPTH=16, push 0x100..0x10F -> `full=1`. Push 0x200:
  - Without the macro: `top_addr=0x10F`, `overflow=1`; 16 pops return 0x10F..0x100.
  - With the macro: `top_addr=0x200`; 16 pops return 0x200, 0x10F..0x101.
- With `count=2` and top 0x44, assert push=pop=1 with `push_addr=0x55` -> `count=2`, `top_addr=0x55`, no flags. With empty and push=pop=1, `push_addr=0x66` -> `count=1`, `top_addr=0x66`, `underflow=1`.
- Push 0x7 while `reset=1` -> `count=0`, `empty=1`, all flags 0.
- Wrap-around: repeat push/pop 40 times at `count` ≈ 15 -> `wr_ptr` wraps past 0 with no corruption; every pop returns the matching pushed value.
